// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv layer scheduler, the convolution
// engine and the layer-level control FSM.
//   - default layer geometry (output map size, filter count bound)
//   - width helpers: filter-index width, engine-local pixel address width,
//     layer-wide feature-map address width
//   - sched_state_t: scheduler FSM state encoding
package conv_pkg;

  localparam int DEF_OUT_W       = 62;
  localparam int DEF_OUT_H       = 62;
  localparam int DEF_MAX_FILTERS = 30;

  // Filter index / count width: must hold the value MAX_FILTERS itself.
  function automatic int fw_of(input int max_filters);
    return $clog2(max_filters + 1);
  endfunction

  function automatic int pix_w_of(input int out_w, input int out_h);
    return $clog2(out_w * out_h);
  endfunction

  function automatic int map_w_of(input int out_w, input int out_h, input int max_filters);
    return $clog2(out_w * out_h * max_filters);
  endfunction

  localparam int OUT_PIX = DEF_OUT_W * DEF_OUT_H;
  localparam int FW      = fw_of(DEF_MAX_FILTERS);
  localparam int PIX_W   = pix_w_of(DEF_OUT_W, DEF_OUT_H);
  localparam int MAP_W   = map_w_of(DEF_OUT_W, DEF_OUT_H, DEF_MAX_FILTERS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// conv_layer_scheduler_if: bundle between the scheduler and its neighbours
// (weight loader, convolution engine, feature-map RAM).
//   master modport (scheduler side):
//     out: wt_load_req, wt_bank_sel, eng_rst, eng_enable, map_we, map_addr, map_data
//     in : wt_load_ack, eng_out_valid, eng_out_addr, eng_out_data, eng_done
//   slave modport: the same signals seen from the environment.
interface conv_layer_scheduler_if #(
  parameter int FW    = 5,
  parameter int PIX_W = 12,
  parameter int MAP_W = 17
) ();

  // weight loader
  logic             wt_load_req;
  logic             wt_load_ack;
  logic [FW-1:0]    wt_bank_sel;
  // convolution engine
  logic             eng_rst;
  logic             eng_enable;
  logic             eng_out_valid;
  logic [PIX_W-1:0] eng_out_addr;
  logic [15:0]      eng_out_data;
  logic             eng_done;
  // feature-map RAM write port
  logic             map_we;
  logic [MAP_W-1:0] map_addr;
  logic [15:0]      map_data;

  modport master (
    output wt_load_req, wt_bank_sel, eng_rst, eng_enable, map_we, map_addr, map_data,
    input  wt_load_ack, eng_out_valid, eng_out_addr, eng_out_data, eng_done
  );

  modport slave (
    input  wt_load_req, wt_bank_sel, eng_rst, eng_enable, map_we, map_addr, map_data,
    output wt_load_ack, eng_out_valid, eng_out_addr, eng_out_data, eng_done
  );

endinterface

// File: rtl/conv_out_addr_map.sv
// conv_out_addr_map: remaps engine-local pixel addresses into the layer-wide
// feature-map address space and registers the RAM write port.
//   clk, reset      : clock, asynchronous active-high reset
//   base_clr        : zero the filter base (start of layer)
//   base_inc        : advance the filter base by one output map
//   pix_valid       : accepted engine pixel this cycle
//   pix_addr/data   : engine-local address and value
//   map_we/addr/data: registered feature-map write, one cycle after pix_valid
module conv_out_addr_map #(
  parameter int PIX_AW  = 12,
  parameter int MAP_AW  = 17,
  parameter int NUM_PIX = 3844
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              base_clr,
  input  logic              base_inc,
  input  logic              pix_valid,
  input  logic [PIX_AW-1:0] pix_addr,
  input  logic [15:0]       pix_data,
  output logic              map_we,
  output logic [MAP_AW-1:0] map_addr,
  output logic [15:0]       map_data
);

  logic [MAP_AW-1:0] base_q, base_d;
  logic              map_we_q, map_we_d;
  logic [MAP_AW-1:0] map_addr_q, map_addr_d;
  logic [15:0]       map_data_q, map_data_d;

  // filter*OUT_W*OUT_H is kept as a running sum so no multiplier is needed;
  // all sums wrap at MAP_AW bits.
  always_comb begin
    base_d     = base_q;
    map_we_d   = pix_valid;
    map_addr_d = map_addr_q;
    map_data_d = map_data_q;
    if (base_clr) begin
      base_d = '0;
    end else if (base_inc) begin
      base_d = base_q + MAP_AW'(NUM_PIX);
    end
    if (pix_valid) begin
      map_addr_d = base_q + MAP_AW'(pix_addr);
      map_data_d = pix_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      map_we_q   <= 1'b0;
      map_addr_q <= '0;
      map_data_q <= '0;
    end else begin
      base_q     <= base_d;
      map_we_q   <= map_we_d;
      map_addr_q <= map_addr_d;
      map_data_q <= map_data_d;
    end
  end

  assign map_we   = map_we_q;
  assign map_addr = map_addr_q;
  assign map_data = map_data_q;

endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: runs the single convolution engine once per filter of
// a conv layer: weight-bank load, engine clear, engine run, pixel-count check.
//   clk, reset        : clock, asynchronous active-high reset
//   start, abort      : layer start pulse (IDLE only), abort level
//   cfg_num_filters   : filter count, clamped to 1..MAX_FILTERS on start
//   busy, done, err   : status; err is a sticky pixel-count / stray-pixel flag
//   bus (master)      : loader, engine and feature-map RAM signals
//   perf_cycles/stall : busy-cycle and weight-load-cycle counters, present
//                       only when CONV_SCHED_PERF_EN is defined
module conv_layer_scheduler
  import conv_pkg::*;
#(
  parameter int  OUT_W       = DEF_OUT_W,
  parameter int  OUT_H       = DEF_OUT_H,
  parameter int  MAX_FILTERS = DEF_MAX_FILTERS,
  localparam int NUM_PIX     = OUT_W * OUT_H,
  localparam int FIL_W       = fw_of(MAX_FILTERS),
  localparam int PIX_AW      = pix_w_of(OUT_W, OUT_H),
  localparam int MAP_AW      = map_w_of(OUT_W, OUT_H, MAX_FILTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FIL_W-1:0] cfg_num_filters,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall,
`endif
  conv_layer_scheduler_if.master bus
);

  // Pixel counter saturates one above the expected count so an overrun can
  // never wrap back onto the correct value.
  localparam int CNT_W   = $clog2(NUM_PIX + 2);
  localparam int CNT_SAT = NUM_PIX + 1;

  sched_state_t     state_q, state_d;
  logic [FIL_W-1:0] idx_q, idx_d;
  logic [FIL_W-1:0] nf_q, nf_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             err_q, err_d;
  logic             eng_rst_q, eng_rst_d;
  logic [FIL_W-1:0] nf_clamped;
  logic             pix_ok;
  logic             base_clr;
  logic             base_inc;
  logic             start_ok;

  assign start_ok = start & ~abort;

  always_comb begin
    if (cfg_num_filters == '0) begin
      nf_clamped = FIL_W'(1);
    end else if (cfg_num_filters > FIL_W'(MAX_FILTERS)) begin
      nf_clamped = FIL_W'(MAX_FILTERS);
    end else begin
      nf_clamped = cfg_num_filters;
    end
  end

  // Only pixels arriving while the engine is enabled reach the map.
  assign pix_ok = bus.eng_out_valid && (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nf_d      = nf_q;
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    base_clr  = 1'b0;
    base_inc  = 1'b0;

    if (bus.eng_out_valid && (state_q != RUN)) begin
      err_d = 1'b1;
    end
    if (pix_ok && (pix_cnt_q != CNT_W'(CNT_SAT))) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          nf_d      = nf_clamped;
          idx_d     = '0;
          err_d     = 1'b0;
          pix_cnt_d = '0;
          base_clr  = 1'b1;
          state_d   = WLOAD;
        end
      end
      WLOAD: begin
        if (bus.wt_load_ack) begin
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (bus.eng_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (pix_cnt_q != CNT_W'(NUM_PIX)) begin
          err_d = 1'b1;
        end
        pix_cnt_d = '0;
        if (idx_q == nf_q - 1'b1) begin
          state_d = FIN;
        end else begin
          idx_d    = idx_q + 1'b1;
          base_inc = 1'b1;
          state_d  = WLOAD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
    end

    eng_rst_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      nf_q      <= FIL_W'(1);
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nf_q      <= nf_d;
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
      eng_rst_q <= eng_rst_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FIN);
  assign err             = err_q;
  assign bus.wt_load_req = (state_q == WLOAD);
  assign bus.wt_bank_sel = idx_q;
  assign bus.eng_rst     = eng_rst_q;
  assign bus.eng_enable  = (state_q == RUN) && !bus.eng_done;

  conv_out_addr_map #(
    .PIX_AW  (PIX_AW),
    .MAP_AW  (MAP_AW),
    .NUM_PIX (NUM_PIX)
  ) u_addr_map (
    .clk       (clk),
    .reset     (reset),
    .base_clr  (base_clr),
    .base_inc  (base_inc),
    .pix_valid (pix_ok),
    .pix_addr  (bus.eng_out_addr),
    .pix_data  (bus.eng_out_data),
    .map_we    (bus.map_we),
    .map_addr  (bus.map_addr),
    .map_data  (bus.map_data)
  );

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == IDLE) begin
      if (start_ok) begin
        perf_cycles_d = '0;
        perf_stall_d  = '0;
      end
    end else begin
      if (perf_cycles_q != '1) begin
        perf_cycles_d = perf_cycles_q + 1'b1;
      end
      if ((state_q == WLOAD) && (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Testbench for conv_layer_scheduler with a 4x4 output map and up to 6 filters.
module tb_conv_layer_scheduler;

  localparam int OW   = 4;
  localparam int OH   = 4;
  localparam int MAXF = 6;
  localparam int NPIX = OW * OH;
  localparam int FW_T = $clog2(MAXF + 1);
  localparam int PW_T = $clog2(NPIX);
  localparam int MW_T = $clog2(NPIX * MAXF);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [FW_T-1:0] cfg_num_filters = '0;
  logic            busy, done, err;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]     perf_cycles, perf_stall;
`endif

  conv_layer_scheduler_if #(.FW(FW_T), .PIX_W(PW_T), .MAP_W(MW_T)) bif ();

  conv_layer_scheduler #(.OUT_W(OW), .OUT_H(OH), .MAX_FILTERS(MAXF)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_num_filters (cfg_num_filters),
    .busy            (busy),
    .done            (done),
    .err             (err),
`ifdef CONV_SCHED_PERF_EN
    .perf_cycles     (perf_cycles),
    .perf_stall      (perf_stall),
`endif
    .bus             (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  // Layer-level expectation per vector: filters actually run and final err.
  typedef struct {
    int cfg;
    int ack_dly;
    int short_f;
    bit same_done;
    bit hold_start;
    int gap_max;
    int exp_nf;
    bit exp_err;
  } vec_t;
  vec_t vecs[6];

  int   req_rises = 0;
  int   done_cnt  = 0;
  int   busy_cyc  = 0;
  logic req_prev  = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  // Monitor: counts load requests, done pulses and busy cycles, and checks
  // every feature-map write against the expected-write queue.
  always @(negedge clk) begin
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (bif.wt_load_req && !req_prev) req_rises++;
      req_prev = bif.wt_load_req;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (bif.map_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL map_write: unexpected write addr=%0d data=%0h, required no write",
                   bif.map_addr, bif.map_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (int'(bif.map_addr) != w.addr || int'(bif.map_data) != w.data) begin
            failures++;
            $display("FAIL map_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                     bif.map_addr, bif.map_data, w.addr, w.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_nf(input int c);
    if (c == 0) return 1;
    if (c > MAXF) return MAXF;
    return c;
  endfunction

  task automatic load_filter(input int f, input int ack_dly);
    int n = 0;
    while (!bif.wt_load_req && n < 50) begin
      tick();
      n++;
    end
    chk("wt_load_req_seen", bif.wt_load_req, 1);
    chk("wt_bank_sel", bif.wt_bank_sel, f);
    repeat (ack_dly - 1) tick();
    bif.wt_load_ack = 1'b1;
    tick();
    bif.wt_load_ack = 1'b0;
    chk("eng_rst_pulse", bif.eng_rst, 1);
    chk("eng_enable_in_clear", bif.eng_enable, 0);
    tick();
    chk("eng_rst_one_cycle", bif.eng_rst, 0);
    chk("eng_enable_in_run", bif.eng_enable, 1);
  endtask

  // Engine model: np pixels with local addresses 0..np-1, optional eng_done.
  task automatic emit_pixels(input int f, input int np, input bit same_done,
                             input int gap_max, input bit finish);
    for (int p = 0; p < np; p++) begin
      bit [31:0] d;
      wr_t w;
      d = $urandom;
      bif.eng_out_valid = 1'b1;
      bif.eng_out_addr  = PW_T'(p);
      bif.eng_out_data  = d[15:0];
      w.addr = f * NPIX + p;
      w.data = int'(d[15:0]);
      exp_q.push_back(w);
      if (finish && same_done && p == np - 1) bif.eng_done = 1'b1;
      tick();
      bif.eng_out_valid = 1'b0;
      bif.eng_done      = 1'b0;
      if (p < np - 1) repeat ($urandom_range(0, gap_max)) tick();
    end
    if (finish && (!same_done || np == 0)) begin
      bif.eng_done = 1'b1;
      #1;
      chk("eng_enable_low_on_done", bif.eng_enable, 0);
      tick();
      bif.eng_done = 1'b0;
    end
  endtask

  task automatic run_layer(input vec_t v);
    int req0, done0, busy0;
    req0  = req_rises;
    done0 = done_cnt;
    busy0 = busy_cyc;
    cfg_num_filters = FW_T'(v.cfg);
    start = 1'b1;
    tick();
    if (!v.hold_start) start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("req_after_start", bif.wt_load_req, 1);
    chk("err_cleared_on_start", err, 0);
    for (int f = 0; f < v.exp_nf; f++) begin
      load_filter(f, v.ack_dly);
      emit_pixels(f, (f == v.short_f) ? NPIX - 1 : NPIX, v.same_done, v.gap_max, 1'b1);
      if (f == v.exp_nf - 1) start = 1'b0;
      chk("busy_in_next", busy, 1);
      tick();
      chk("err_after_next", err, (v.short_f >= 0 && f >= v.short_f) ? 1 : 0);
    end
    chk("done_pulse", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_fall", busy, 0);
    chk("err_final", err, v.exp_err);
    chk("req_count", req_rises - req0, v.exp_nf);
    chk("done_count", done_cnt - done0, 1);
    chk("writes_pending", exp_q.size(), 0);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_cycles", perf_cycles, busy_cyc - busy0);
    chk("perf_stall", perf_stall, v.ack_dly * v.exp_nf);
`endif
  endtask

  initial begin
    int dc;
    vec_t rv;
    bif.wt_load_ack   = 1'b0;
    bif.eng_out_valid = 1'b0;
    bif.eng_out_addr  = '0;
    bif.eng_out_data  = '0;
    bif.eng_done      = 1'b0;

    //            cfg ack short same hold gap nf  err
    vecs[0] = '{  2,  1,  -1,   0,   0,   0,  2,  0 };  // two filters, map 0..15 then 16..31
    vecs[1] = '{  0,  1,  -1,   1,   0,   0,  1,  0 };  // zero clamps to one filter
    vecs[2] = '{  2,  2,   1,   0,   0,   1,  2,  1 };  // filter 1 short by one pixel
    vecs[3] = '{  2,  1,  -1,   0,   1,   0,  2,  0 };  // start held while busy
    vecs[4] = '{  7,  1,  -1,   1,   0,   0,  6,  0 };  // over max clamps to MAXF
    vecs[5] = '{  2,  5,  -1,   0,   0,   2,  2,  0 };  // slow loader

    // Reset state
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", bif.wt_load_req, 0);
    chk("rst_bank", bif.wt_bank_sel, 0);
    chk("rst_eng_rst", bif.eng_rst, 0);
    chk("rst_map_we", bif.map_we, 0);
    chk("rst_map_addr", bif.map_addr, 0);
    chk("rst_map_data", bif.map_data, 0);
    reset = 1'b0;
    tick();

    // Stray pixel in IDLE: dropped, flags err
    bif.eng_out_valid = 1'b1;
    bif.eng_out_data  = 16'hbeef;
    tick();
    bif.eng_out_valid = 1'b0;
    chk("stray_pixel_dropped", bif.map_we, 0);
    chk("stray_pixel_err", err, 1);
    $display("stray pixel in IDLE: err=%0d", err);

    // start together with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_layer(vecs[i]);
      $display("vector %0d: cfg=%0d filters=%0d err=%0d", i, vecs[i].cfg, vecs[i].exp_nf, err);
    end

    // Abort during RUN of the second of three filters
    cfg_num_filters = FW_T'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_filter(0, 1);
    emit_pixels(0, NPIX, 1'b0, 0, 1'b1);
    tick();
    load_filter(1, 1);
    emit_pixels(1, 3, 1'b0, 0, 1'b0);
    dc = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_enable", bif.eng_enable, 0);
    chk("abort_req", bif.wt_load_req, 0);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - dc, 0);
    chk("abort_writes_pending", exp_q.size(), 0);
    $display("abort in RUN of filter 1: busy=%0d", busy);
    run_layer(vecs[1]);

    // Asynchronous reset in the middle of RUN
    cfg_num_filters = FW_T'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_filter(0, 1);
    emit_pixels(0, 5, 1'b0, 0, 1'b0);
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_enable", bif.eng_enable, 0);
    chk("midrst_map_we", bif.map_we, 0);
    chk("midrst_map_addr", bif.map_addr, 0);
    chk("midrst_bank", bif.wt_bank_sel, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_writes_pending", exp_q.size(), 0);
    $display("async reset mid-RUN: busy=%0d", busy);

    // Randomized layers
    for (int r = 0; r < 4; r++) begin
      rv.cfg        = $urandom_range(0, MAXF + 1);
      rv.exp_nf     = model_nf(rv.cfg);
      rv.ack_dly    = $urandom_range(1, 4);
      rv.short_f    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rv.exp_nf - 1) : -1;
      rv.same_done  = 1'($urandom_range(0, 1));
      rv.hold_start = 1'b0;
      rv.gap_max    = $urandom_range(0, 2);
      rv.exp_err    = (rv.short_f >= 0);
      run_layer(rv);
      $display("random %0d: cfg=%0d filters=%0d short=%0d err=%0d", r, rv.cfg, rv.exp_nf, rv.short_f, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
